// File: rtl/tlb_unit_if.sv
// Bus bundle for tlb_unit: CP0 entry access, probe control/result, translation lookup.
// Strobes are single-cycle; each result is qualified by its own valid pulse.
interface tlb_unit_if;
    logic [85:0] cp0_tlb_conf_out;
    logic [3:0]  cp0_index;
    logic [3:0]  cp0_random;
    logic        tlbwi;
    logic        tlbwr;
    logic        tlbr;
    logic        tlbp_req;
    logic [85:0] cp0_tlb_conf_in;
    logic        tlbr_valid;
    logic        tlb_busy;
    logic        probe_done;
    logic        miss_probe;
    logic [3:0]  matched_index_probe;
    logic        lookup_req;
    logic [31:0] lookup_vaddr;
    logic [7:0]  lookup_asid;
    logic        lookup_valid;
    logic [31:0] lookup_paddr;
    logic        lookup_miss;
    logic        lookup_invalid;
    logic        lookup_dirty;
    logic        lookup_cached;
    logic [1:0]  probe_state;

    modport master (
        output cp0_tlb_conf_out, cp0_index, cp0_random, tlbwi, tlbwr, tlbr, tlbp_req,
        output lookup_req, lookup_vaddr, lookup_asid,
        input  cp0_tlb_conf_in, tlbr_valid, tlb_busy, probe_done, miss_probe,
        input  matched_index_probe, lookup_valid, lookup_paddr, lookup_miss,
        input  lookup_invalid, lookup_dirty, lookup_cached, probe_state
    );

    modport slave (
        input  cp0_tlb_conf_out, cp0_index, cp0_random, tlbwi, tlbwr, tlbr, tlbp_req,
        input  lookup_req, lookup_vaddr, lookup_asid,
        output cp0_tlb_conf_in, tlbr_valid, tlb_busy, probe_done, miss_probe,
        output matched_index_probe, lookup_valid, lookup_paddr, lookup_miss,
        output lookup_invalid, lookup_dirty, lookup_cached, probe_state
    );
endinterface

// File: rtl/tlb_unit.sv
// 16-entry MIPS-style TLB: indexed/random write, read, probe FSM and 1-cycle lookup.
// Define TLB_FAST_PROBE_EN to compare all entries in a single SCAN cycle.
module tlb_unit (
    input  logic           clk,
    input  logic           rst_n,
    tlb_unit_if.slave      bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} probe_state_t;

    logic [85:0]  entries [16];
    probe_state_t state_q, state_d;
    logic [3:0]   scan_idx_q, scan_idx_d;
    logic [18:0]  key_vpn_q;
    logic [7:0]   key_asid_q;
    logic         miss_q;
    logic [3:0]   matched_q;
    logic         set_result;
    logic         result_miss;
    logic [3:0]   result_idx;
    logic         scan_hit;
    logic [3:0]   scan_hit_idx;
    logic         scan_last;
    logic         lk_hit;
    logic [3:0]   lk_idx;
    logic [19:0]  lk_pfn;
    logic [2:0]   lk_c;
    logic         lk_d;
    logic         lk_v;

    // tag = entry[85:58] = {VPN2, G, ASID}
    function automatic logic entry_match(input logic [27:0] tag, input logic [18:0] vpn,
                                         input logic [7:0] asid);
        return (tag[27:9] == vpn) && (tag[8] || (tag[7:0] == asid));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) entries[i] <= '0;
        end else if (bus.tlbwi) begin
            entries[bus.cp0_index] <= bus.cp0_tlb_conf_out;
        end else if (bus.tlbwr) begin
            entries[bus.cp0_random] <= bus.cp0_tlb_conf_out;
        end
    end

    // Read port samples before the same-edge write lands, so it returns old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tlbr_valid      <= 1'b0;
            bus.cp0_tlb_conf_in <= '0;
        end else begin
            bus.tlbr_valid <= bus.tlbr;
            if (bus.tlbr) bus.cp0_tlb_conf_in <= entries[bus.cp0_index];
        end
    end

    // Descending loop so the lowest matching index is the one left standing.
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (entry_match(entries[i][85:58], bus.lookup_vaddr[31:13], bus.lookup_asid)) begin
                lk_hit = 1'b1;
                lk_idx = 4'(i);
            end
        end
    end

    always_comb begin
        if (bus.lookup_vaddr[12]) begin
            lk_pfn = entries[lk_idx][24:5];
            lk_c   = entries[lk_idx][4:2];
            lk_d   = entries[lk_idx][1];
            lk_v   = entries[lk_idx][0];
        end else begin
            lk_pfn = entries[lk_idx][53:34];
            lk_c   = entries[lk_idx][33:31];
            lk_d   = entries[lk_idx][30];
            lk_v   = entries[lk_idx][29];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.lookup_valid   <= 1'b0;
            bus.lookup_paddr   <= '0;
            bus.lookup_miss    <= 1'b0;
            bus.lookup_invalid <= 1'b0;
            bus.lookup_dirty   <= 1'b0;
            bus.lookup_cached  <= 1'b0;
        end else begin
            bus.lookup_valid <= bus.lookup_req;
            if (bus.lookup_req) begin
                bus.lookup_paddr   <= lk_hit ? {lk_pfn, bus.lookup_vaddr[11:0]} : 32'd0;
                bus.lookup_miss    <= !lk_hit;
                bus.lookup_invalid <= lk_hit && !lk_v;
                bus.lookup_dirty   <= lk_hit && lk_d;
                bus.lookup_cached  <= lk_hit && (lk_c != 3'd2);
            end
        end
    end

`ifdef TLB_FAST_PROBE_EN
    always_comb begin
        scan_hit     = 1'b0;
        scan_hit_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (entry_match(entries[i][85:58], key_vpn_q, key_asid_q)) begin
                scan_hit     = 1'b1;
                scan_hit_idx = 4'(i);
            end
        end
    end
    assign scan_last = 1'b1;
`else
    assign scan_hit     = entry_match(entries[scan_idx_q][85:58], key_vpn_q, key_asid_q);
    assign scan_hit_idx = scan_idx_q;
    assign scan_last    = (scan_idx_q == 4'hF);
`endif

    always_comb begin
        state_d     = state_q;
        scan_idx_d  = scan_idx_q;
        set_result  = 1'b0;
        result_miss = 1'b0;
        result_idx  = '0;
        case (state_q)
            IDLE: begin
                if (bus.tlbp_req) begin
                    state_d    = SCAN;
                    scan_idx_d = '0;
                end
            end
            SCAN: begin
                if (scan_hit) begin
                    set_result = 1'b1;
                    result_idx = scan_hit_idx;
                    state_d    = DONE;
                end else if (scan_last) begin
                    set_result  = 1'b1;
                    result_miss = 1'b1;
                    state_d     = DONE;
                end else begin
                    scan_idx_d = scan_idx_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            scan_idx_q <= '0;
            key_vpn_q  <= '0;
            key_asid_q <= '0;
            miss_q     <= 1'b0;
            matched_q  <= '0;
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            if (state_q == IDLE && bus.tlbp_req) begin
                key_vpn_q  <= bus.cp0_tlb_conf_out[85:67];
                key_asid_q <= bus.cp0_tlb_conf_out[65:58];
            end
            if (set_result) begin
                miss_q    <= result_miss;
                matched_q <= result_idx;
            end
        end
    end

    assign bus.tlb_busy            = (state_q != IDLE);
    assign bus.probe_done          = (state_q == DONE);
    assign bus.miss_probe          = miss_q;
    assign bus.matched_index_probe = matched_q;
    assign bus.probe_state         = state_q;
endmodule

// File: tb/tb_tlb_unit.sv
// Directed bench for tlb_unit: drivers push expected results, a negedge monitor pops and compares.
module tb_tlb_unit;
    logic clk;
    logic rst_n;
    tlb_unit_if bus();

    tlb_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef TLB_FAST_PROBE_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [35:0] exp_lk_q[$];   // {miss, invalid, dirty, cached, paddr}
    logic [85:0] exp_rd_q[$];
    logic [36:0] exp_pr_q[$];   // {done_cycle, miss, index}
    logic [35:0] mon_lk;
    logic [85:0] mon_rd;
    logic [36:0] mon_pr;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required completion before 100000 ns");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [85:0] act, input logic [85:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [28:0] lo(input logic [23:0] pfn, input logic [2:0] c,
                                       input logic d, input logic v);
        return {pfn, c, d, v};
    endfunction

    function automatic logic [85:0] ent(input logic [18:0] vpn, input logic g, input logic [7:0] asid,
                                        input logic [28:0] lo0, input logic [28:0] lo1);
        return {vpn, g, asid, lo0, lo1};
    endfunction

    // Monitor: every DUT result strobe must match the head of its expected queue.
    always @(negedge clk) begin
        if (bus.lookup_valid) begin
            if (exp_lk_q.size() == 0) begin
                check("lookup_unexpected", 86'd1, 86'd0);
            end else begin
                mon_lk = exp_lk_q.pop_front();
                check("lookup_flags", {bus.lookup_miss, bus.lookup_invalid, bus.lookup_dirty,
                                       bus.lookup_cached}, mon_lk[35:32]);
                check("lookup_paddr", bus.lookup_paddr, mon_lk[31:0]);
            end
        end
        if (bus.tlbr_valid) begin
            if (exp_rd_q.size() == 0) begin
                check("tlbr_unexpected", 86'd1, 86'd0);
            end else begin
                mon_rd = exp_rd_q.pop_front();
                check("tlbr_data", bus.cp0_tlb_conf_in, mon_rd);
            end
        end
        if (bus.probe_done) begin
            if (exp_pr_q.size() == 0) begin
                check("probe_unexpected", 86'd1, 86'd0);
            end else begin
                mon_pr = exp_pr_q.pop_front();
                check("probe_cycle", cyc, mon_pr[36:5]);
                check("probe_miss", bus.miss_probe, mon_pr[4]);
                check("probe_index", bus.matched_index_probe, mon_pr[3:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_lk_q.size() + exp_rd_q.size() + exp_pr_q.size()) != 0 && n < 40) begin
            tick();
            n++;
        end
        check("drain_pending", exp_lk_q.size() + exp_rd_q.size() + exp_pr_q.size(), 86'd0);
        exp_lk_q.delete();
        exp_rd_q.delete();
        exp_pr_q.delete();
    endtask

    task automatic write_entry(input logic [3:0] idx, input logic [85:0] e, input bit random);
        bus.cp0_tlb_conf_out = e;
        if (random) begin
            bus.cp0_random = idx;
            bus.tlbwr = 1'b1;
        end else begin
            bus.cp0_index = idx;
            bus.tlbwi = 1'b1;
        end
        tick();
        bus.tlbwi = 1'b0;
        bus.tlbwr = 1'b0;
    endtask

    task automatic read_entry(input logic [3:0] idx, input logic [85:0] exp);
        bus.cp0_index = idx;
        bus.tlbr = 1'b1;
        exp_rd_q.push_back(exp);
        tick();
        bus.tlbr = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] va, input logic [7:0] asid, input logic [3:0] flags,
                          input logic [31:0] paddr);
        bus.lookup_vaddr = va;
        bus.lookup_asid  = asid;
        bus.lookup_req   = 1'b1;
        exp_lk_q.push_back({flags, paddr});
        tick();
        bus.lookup_req = 1'b0;
    endtask

    task automatic probe(input logic [18:0] vpn, input logic [7:0] asid, input logic miss,
                         input logic [3:0] idx, input int lat_seq);
        int lat;
        lat = FAST ? 2 : lat_seq;
        bus.cp0_tlb_conf_out = {vpn, 1'b0, asid, 58'd0};
        bus.tlbp_req = 1'b1;
        exp_pr_q.push_back({32'(cyc + lat), miss, idx});
        tick();
        bus.tlbp_req = 1'b0;
        check("busy_after_req", bus.tlb_busy, 86'd1);
    endtask

    logic [85:0] e5, e5g, e6, ex, e12, e7a, e7b, e3, e9, e2;

    initial begin
        e5  = ent(19'h00400, 1'b0, 8'h12, lo(24'h001234, 3'd3, 1'b1, 1'b1), lo(24'h00ABCD, 3'd2, 1'b0, 1'b1));
        e5g = ent(19'h00400, 1'b1, 8'h12, lo(24'h001234, 3'd3, 1'b1, 1'b1), lo(24'h00ABCD, 3'd2, 1'b0, 1'b1));
        e6  = ent(19'h00500, 1'b0, 8'h12, lo(24'h000777, 3'd0, 1'b0, 1'b0), 29'd0);
        ex  = ent(19'h00777, 1'b0, 8'h05, lo(24'h000101, 3'd3, 1'b0, 1'b1), lo(24'h000202, 3'd3, 1'b0, 1'b1));
        e12 = ent(19'h00600, 1'b0, 8'h12, lo(24'h000055, 3'd3, 1'b0, 1'b1), 29'd0);
        e7a = ent(19'h0AAAA, 1'b0, 8'h07, lo(24'h0000AA, 3'd3, 1'b1, 1'b1), lo(24'h0000BB, 3'd3, 1'b0, 1'b1));
        e7b = ent(19'h0AAAA, 1'b0, 8'h07, lo(24'h0000CC, 3'd1, 1'b1, 1'b1), lo(24'h0000DD, 3'd3, 1'b1, 1'b0));
        e3  = ent(19'h00123, 1'b0, 8'h44, lo(24'h000333, 3'd3, 1'b1, 1'b1), 29'd0);
        e9  = ent(19'h00123, 1'b1, 8'h00, lo(24'h000999, 3'd2, 1'b0, 1'b1), 29'd0);
        e2  = ent(19'h00ABC, 1'b0, 8'h01, lo(24'h002222, 3'd3, 1'b0, 1'b1), 29'd0);

        rst_n = 1'b0;
        bus.cp0_tlb_conf_out = '0;
        bus.cp0_index = '0;
        bus.cp0_random = '0;
        bus.tlbwi = 1'b0;
        bus.tlbwr = 1'b0;
        bus.tlbr = 1'b0;
        bus.tlbp_req = 1'b0;
        bus.lookup_req = 1'b0;
        bus.lookup_vaddr = '0;
        bus.lookup_asid = '0;
        repeat (2) tick();

        check("rst_strobes", {bus.tlb_busy, bus.probe_done, bus.tlbr_valid, bus.lookup_valid}, 86'd0);
        check("rst_probe_result", {bus.miss_probe, bus.matched_index_probe}, 86'd0);
        check("rst_conf_in", bus.cp0_tlb_conf_in, 86'd0);
        check("rst_lookup", {bus.lookup_miss, bus.lookup_invalid, bus.lookup_dirty,
                             bus.lookup_cached, bus.lookup_paddr}, 86'd0);
        check("rst_state", bus.probe_state, 86'd0);
        rst_n = 1'b1;
        tick();

        // Basic translation, Lo1 page select, ASID mismatch, then global hit
        write_entry(4'd5, e5, 1'b0);
        lookup(32'h00800ABC, 8'h12, 4'b0011, 32'h01234ABC);
        lookup(32'h00801ABC, 8'h12, 4'b0000, 32'h0ABCDABC);
        lookup(32'h00800ABC, 8'h34, 4'b1000, 32'h00000000);
        write_entry(4'd5, e5g, 1'b0);
        lookup(32'h00800ABC, 8'h34, 4'b0011, 32'h01234ABC);
        drain();
        read_entry(4'd5, e5g);

        // Random write of an invalid mapping
        write_entry(4'd6, e6, 1'b1);
        lookup(32'h00A00123, 8'h12, 4'b0101, 32'h00777123);
        drain();

        // tlbwi and tlbwr together: only the indexed write lands
        bus.cp0_tlb_conf_out = ex;
        bus.cp0_index = 4'd10;
        bus.cp0_random = 4'd11;
        bus.tlbwi = 1'b1;
        bus.tlbwr = 1'b1;
        tick();
        bus.tlbwi = 1'b0;
        bus.tlbwr = 1'b0;
        read_entry(4'd11, 86'd0);
        read_entry(4'd10, ex);
        drain();

        // Lookup in the same cycle as the write sees pre-write contents
        bus.cp0_tlb_conf_out = e12;
        bus.cp0_index = 4'd12;
        bus.tlbwi = 1'b1;
        bus.lookup_vaddr = 32'h00C00000;
        bus.lookup_asid = 8'h12;
        bus.lookup_req = 1'b1;
        exp_lk_q.push_back({4'b1000, 32'h0});
        tick();
        bus.tlbwi = 1'b0;
        bus.lookup_req = 1'b0;
        lookup(32'h00C00000, 8'h12, 4'b0001, 32'h00055000);
        drain();

        // Read together with write to the same index returns the old entry
        write_entry(4'd7, e7a, 1'b0);
        bus.cp0_tlb_conf_out = e7b;
        bus.cp0_index = 4'd7;
        bus.tlbwi = 1'b1;
        bus.tlbr = 1'b1;
        exp_rd_q.push_back(e7a);
        tick();
        bus.tlbwi = 1'b0;
        bus.tlbr = 1'b0;
        read_entry(4'd7, e7b);
        drain();
        tick();
        tick();
        check("conf_in_hold", bus.cp0_tlb_conf_in, e7b);
        check("tlbr_valid_idle", bus.tlbr_valid, 86'd0);

        // Two matching entries: lowest index wins for lookup and probe
        write_entry(4'd3, e3, 1'b0);
        write_entry(4'd9, e9, 1'b0);
        lookup(32'h00246000, 8'h44, 4'b0011, 32'h00333000);
        drain();
        probe(19'h00123, 8'h44, 1'b0, 4'd3, 5);
        drain();
        repeat (3) tick();
        check("probe_hold", {bus.miss_probe, bus.matched_index_probe}, {1'b0, 4'd3});
        check("busy_idle", bus.tlb_busy, 86'd0);
        probe(19'h00600, 8'h12, 1'b0, 4'd12, 14);
        drain();

        // Full-length miss; a second request mid-scan must be ignored
        probe(19'h7FFFF, 8'h01, 1'b1, 4'd0, 17);
        bus.cp0_tlb_conf_out = {19'h00123, 1'b0, 8'h44, 58'd0};
        bus.tlbp_req = 1'b1;
        tick();
        bus.tlbp_req = 1'b0;
        drain();
        repeat (3) tick();

        // Reset during SCAN aborts the probe and clears the table
        write_entry(4'd2, e2, 1'b0);
        lookup(32'h01578456, 8'h01, 4'b0001, 32'h02222456);
        drain();
        probe(19'h7FFFF, 8'h01, 1'b1, 4'd0, 17);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("busy_on_reset", bus.tlb_busy, 86'd0);
        check("done_on_reset", bus.probe_done, 86'd0);
        check("miss_probe_on_reset", bus.miss_probe, 86'd0);
        exp_pr_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        lookup(32'h01578456, 8'h01, 4'b1000, 32'h00000000);
        repeat (20) tick();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
